// File: rtl/graph_mem_pkg.sv
// graph_mem_arbiter shared types.
// Kinds, tag bundle, default latency.
package graph_mem_pkg;

  typedef enum logic {
    KIND_IDX  = 1'b0,
    KIND_EDGE = 1'b1
  } req_kind_t;

  localparam int MEM_LATENCY_DEFAULT = 2;
  localparam int TAG_ID_W = 8;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/graph_mem_arbiter_rr_pick.sv
// Rotating-priority one-hot picker.
// First set bit at or after ptr wins.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'((int'(ptr) + k) % N);
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/graph_mem_arbiter.sv
// Round-robin arbiter sharing graph_memory
// read ports among graph processors.
module graph_mem_arbiter
  import graph_mem_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int PROC_BITS   = 4,
  parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_REQ-1:0]        req_valid_in,
  input  logic [NUM_REQ-1:0]        req_kind_in,
  input  logic [NUM_REQ-1:0][31:0]  req_addr_in,
  output logic [NUM_REQ-1:0]        req_ready_out,
  output logic [NUM_REQ-1:0]        resp_valid_out,
  output logic [NUM_REQ-1:0][31:0]  resp_data_out,
  output logic [31+PROC_BITS:0]     idx_addr_out,
  output logic                      idx_valid_out,
  output logic [31+PROC_BITS:0]     data_addra_out,
  output logic [31+PROC_BITS:0]     data_addrb_out,
  output logic                      data_validina_out,
  output logic                      data_validinb_out,
  input  logic [31:0]               rowidx_in,
  input  logic [31:0]               data_a_in,
  input  logic [31:0]               data_b_in
);

  localparam int IW = (NUM_REQ > 1) ?
                      $clog2(NUM_REQ) : 1;
  localparam int AW = 32 + PROC_BITS;

  logic [NUM_REQ-1:0] idx_req;
  logic [NUM_REQ-1:0] edge_req;
  logic [NUM_REQ-1:0] b_req;
  logic [NUM_REQ-1:0] idx_gnt;
  logic [NUM_REQ-1:0] a_gnt;
  logic [NUM_REQ-1:0] b_gnt;
  logic [IW-1:0]      idx_ptr;
  logic [IW-1:0]      data_ptr;
  logic [IW-1:0]      b_ptr;
  logic [IW-1:0]      idx_win;
  logic [IW-1:0]      a_win;
  logic [IW-1:0]      b_win;
  logic               idx_any;
  logic               a_any;
  logic               b_any;

  tag_t [2:0][MEM_LATENCY:0] pipe;
  tag_t [2:0]                new_tag;
  logic [2:0][31:0]          ch_data;
  logic [NUM_REQ-1:0]        rv_d;
  logic [NUM_REQ-1:0][31:0]  rd_d;

  function automatic logic [IW-1:0] inc(
    input logic [IW-1:0] p
  );
    return (int'(p) == NUM_REQ - 1) ?
           '0 : p + IW'(1);
  endfunction

  function automatic logic [AW-1:0] maddr(
    input logic [IW-1:0] w
  );
    return {PROC_BITS'(w), req_addr_in[w]};
  endfunction

  always_comb begin
    idx_req  = '0;
    edge_req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid_in[i]) begin
        if (req_kind_t'(req_kind_in[i]) == KIND_EDGE)
          edge_req[i] = 1'b1;
        else
          idx_req[i] = 1'b1;
      end
    end
  end

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_idx (
    .req (idx_req),
    .ptr (idx_ptr),
    .gnt (idx_gnt),
    .idx (idx_win),
    .any (idx_any)
  );

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_ea (
    .req (edge_req),
    .ptr (data_ptr),
    .gnt (a_gnt),
    .idx (a_win),
    .any (a_any)
  );

  // B searches after the A winner, so B is empty whenever A is
  assign b_req = edge_req & ~a_gnt;
  assign b_ptr = inc(a_win);

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_eb (
    .req (b_req),
    .ptr (b_ptr),
    .gnt (b_gnt),
    .idx (b_win),
    .any (b_any)
  );

  assign req_ready_out = rst_in ? '0 :
                         (idx_gnt | a_gnt | b_gnt);

  assign ch_data = {data_b_in, data_a_in, rowidx_in};

  always_comb begin
    new_tag[0] = '{valid: idx_any,
                   id: TAG_ID_W'(idx_win)};
    new_tag[1] = '{valid: a_any,
                   id: TAG_ID_W'(a_win)};
    new_tag[2] = '{valid: b_any,
                   id: TAG_ID_W'(b_win)};
  end

  always_comb begin
    rv_d = '0;
    rd_d = resp_data_out;
    for (int r = 0; r < NUM_REQ; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (pipe[c][MEM_LATENCY].valid &&
            pipe[c][MEM_LATENCY].id ==
            TAG_ID_W'(r)) begin
          rv_d[r] = 1'b1;
          rd_d[r] = ch_data[c];
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      idx_ptr           <= '0;
      data_ptr          <= '0;
      idx_addr_out      <= '0;
      data_addra_out    <= '0;
      data_addrb_out    <= '0;
      idx_valid_out     <= 1'b0;
      data_validina_out <= 1'b0;
      data_validinb_out <= 1'b0;
      pipe              <= '0;
      resp_valid_out    <= '0;
      resp_data_out     <= '0;
    end else begin
      if (idx_any) begin
        idx_ptr      <= inc(idx_win);
        idx_addr_out <= maddr(idx_win);
      end
      if (b_any)
        data_ptr <= inc(b_win);
      else if (a_any)
        data_ptr <= inc(a_win);
      if (a_any)
        data_addra_out <= maddr(a_win);
      if (b_any)
        data_addrb_out <= maddr(b_win);
      idx_valid_out     <= idx_any;
      data_validina_out <= a_any;
      data_validinb_out <= b_any;
      for (int c = 0; c < 3; c++) begin
        pipe[c][0] <= new_tag[c];
        for (int s = 1; s <= MEM_LATENCY; s++)
          pipe[c][s] <= pipe[c][s-1];
      end
      resp_valid_out <= rv_d;
      resp_data_out  <= rd_d;
    end
  end

endmodule

// File: tb/tb_graph_mem_arbiter.sv
// Random + directed bench for graph_mem_arbiter
// against a queue-based reference model.
module tb_graph_mem_arbiter;

  localparam int ML = 2;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic [3:0]       req_valid_in;
  logic [3:0]       req_kind_in;
  logic [3:0][31:0] req_addr_in;
  logic [3:0]       req_ready_out;
  logic [3:0]       resp_valid_out;
  logic [3:0][31:0] resp_data_out;
  logic [35:0]      idx_addr_out;
  logic             idx_valid_out;
  logic [35:0]      data_addra_out;
  logic [35:0]      data_addrb_out;
  logic             data_validina_out;
  logic             data_validinb_out;
  logic [31:0]      rowidx_in;
  logic [31:0]      data_a_in;
  logic [31:0]      data_b_in;

  graph_mem_arbiter #(
    .NUM_REQ(4), .PROC_BITS(4), .MEM_LATENCY(ML)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .req_valid_in      (req_valid_in),
    .req_kind_in       (req_kind_in),
    .req_addr_in       (req_addr_in),
    .req_ready_out     (req_ready_out),
    .resp_valid_out    (resp_valid_out),
    .resp_data_out     (resp_data_out),
    .idx_addr_out      (idx_addr_out),
    .idx_valid_out     (idx_valid_out),
    .data_addra_out    (data_addra_out),
    .data_addrb_out    (data_addrb_out),
    .data_validina_out (data_validina_out),
    .data_validinb_out (data_validinb_out),
    .rowidx_in         (rowidx_in),
    .data_a_in         (data_a_in),
    .data_b_in         (data_b_in)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int          due;
    logic [1:0]  id;
    logic [31:0] d;
  } rsp_t;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int iptr = 0;
  int dptr = 0;
  int rsp_seen = 0;
  int gcnt [4];

  logic        e_iv = 0, e_av = 0, e_bv = 0;
  logic [35:0] e_ia = '0, e_aa = '0, e_ba = '0;
  logic [3:0][31:0] e_rd = '0;
  rsp_t        pend [$];
  logic [35:0] hq_i [$], hq_a [$], hq_b [$];

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] frow(
    input logic [35:0] x);
    return (x[31:0] * 32'd3) ^
           {x[35:32], 28'h1234567};
  endfunction

  function automatic logic [31:0] fedge(
    input logic [35:0] x);
    return ~x[31:0] ^ {8'h5A, 20'h0, x[35:32]};
  endfunction

  function automatic logic [3:0][31:0] rnd_addr();
    logic [3:0][31:0] a;
    for (int i = 0; i < 4; i++) a[i] = $urandom;
    return a;
  endfunction

  task automatic mem_push(ref logic [35:0] q[$],
                          input logic [35:0] v);
    q.push_back(v);
    if (q.size() > ML + 1) void'(q.pop_front());
  endtask

  task automatic step(input logic [3:0] v,
                      input logic [3:0] k,
                      input logic [3:0][31:0] a);
    int gi, ga, gb, j;
    logic [3:0] er, ev;
    logic [3:0][31:0] ed;
    @(negedge clk_in);
    req_valid_in = v;
    req_kind_in  = k;
    req_addr_in  = a;
    #1;
    gi = -1; ga = -1; gb = -1;
    for (int n = 0; n < 4; n++) begin
      j = (iptr + n) % 4;
      if (gi < 0 && v[j] && !k[j]) gi = j;
    end
    for (int n = 0; n < 4; n++) begin
      j = (dptr + n) % 4;
      if (v[j] && k[j]) begin
        if (ga < 0) ga = j;
        else if (gb < 0) gb = j;
      end
    end
    er = '0;
    if (gi >= 0) er[gi] = 1'b1;
    if (ga >= 0) er[ga] = 1'b1;
    if (gb >= 0) er[gb] = 1'b1;
    for (int i = 0; i < 4; i++) gcnt[i] += int'(req_ready_out[i]);
    chk("ready", req_ready_out, er);
    chk("idx_v", idx_valid_out, e_iv);
    chk("idx_a", idx_addr_out, e_ia);
    chk("a_v", data_validina_out, e_av);
    chk("a_a", data_addra_out, e_aa);
    chk("b_v", data_validinb_out, e_bv);
    chk("b_a", data_addrb_out, e_ba);
    ev = '0;
    ed = e_rd;
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].due == cyc) begin
        ev[pend[i].id] = 1'b1;
        ed[pend[i].id] = pend[i].d;
        pend.delete(i);
      end
    end
    chk("rsp_v", resp_valid_out, ev);
    chk("rsp_d", resp_data_out, ed);
    e_rd = ed;
    rsp_seen += $countones(resp_valid_out);
    mem_push(hq_i, idx_addr_out);
    mem_push(hq_a, data_addra_out);
    mem_push(hq_b, data_addrb_out);
    rowidx_in = (hq_i.size() == ML + 1) ? frow(hq_i[0]) : '0;
    data_a_in = (hq_a.size() == ML + 1) ? fedge(hq_a[0]) : '0;
    data_b_in = (hq_b.size() == ML + 1) ? fedge(hq_b[0]) : '0;
    e_iv = (gi >= 0);
    e_av = (ga >= 0);
    e_bv = (gb >= 0);
    if (gi >= 0) begin
      e_ia = {gi[3:0], a[gi]};
      iptr = (gi + 1) % 4;
      pend.push_back('{cyc + 2 + ML, 2'(gi), frow(e_ia)});
    end
    if (ga >= 0) begin
      e_aa = {ga[3:0], a[ga]};
      dptr = (ga + 1) % 4;
      pend.push_back('{cyc + 2 + ML, 2'(ga), fedge(e_aa)});
    end
    if (gb >= 0) begin
      e_ba = {gb[3:0], a[gb]};
      dptr = (gb + 1) % 4;
      pend.push_back('{cyc + 2 + ML, 2'(gb), fedge(e_ba)});
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'h0, 4'h0, rnd_addr());
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_iv"}, idx_valid_out, 0);
    chk({tag, "_ia"}, idx_addr_out, 0);
    chk({tag, "_av"}, data_validina_out, 0);
    chk({tag, "_aa"}, data_addra_out, 0);
    chk({tag, "_bv"}, data_validinb_out, 0);
    chk({tag, "_ba"}, data_addrb_out, 0);
    chk({tag, "_rv"}, resp_valid_out, 0);
    chk({tag, "_rd"}, resp_data_out, 0);
  endtask

  task automatic reset_pulse();
    @(negedge clk_in);
    req_valid_in = '0;
    rst_in = 1'b1;
    #1;
    check_zero("arst");
    pend.delete();
    iptr = 0; dptr = 0;
    e_iv = 0; e_av = 0; e_bv = 0;
    e_ia = '0; e_aa = '0; e_ba = '0;
    e_rd = '0;
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  logic [3:0][31:0] a4;

  initial begin
    rst_in = 1'b1;
    req_valid_in = '0;
    req_kind_in = '0;
    req_addr_in = '0;
    rowidx_in = '0;
    data_a_in = '0;
    data_b_in = '0;
    @(negedge clk_in);
    #1;
    check_zero("rst");
    rst_in = 1'b0;

    // single row-index read from requester 2
    a4 = '0;
    a4[2] = 32'h10;
    step(4'b0100, 4'b0000, a4);
    idle(6);

    // four simultaneous edge requests
    for (int i = 0; i < 4; i++) a4[i] = i;
    step(4'b1111, 4'b1111, a4);
    step(4'b1100, 4'b1111, a4);
    idle(6);

    // lone edge requester 3
    step(4'b1000, 4'b1000, rnd_addr());
    idle(6);

    // fairness under continuous edge load
    for (int i = 0; i < 4; i++) gcnt[i] = 0;
    for (int i = 0; i < 40; i++) step(4'hF, 4'hF, rnd_addr());
    for (int i = 0; i < 4; i++) chk($sformatf("fair%0d", i), gcnt[i], 20);
    idle(6);

    // mixed row-index and edge traffic
    rsp_seen = 0;
    for (int i = 0; i < 20; i++) step(4'b1011, 4'b1010, rnd_addr());
    idle(6);
    chk("mix_rsp", rsp_seen, 60);

    // random traffic
    for (int i = 0; i < 300; i++)
      step(4'($urandom), 4'($urandom), rnd_addr());
    idle(6);

    // reset with grants in flight
    step(4'b0111, 4'b0110, rnd_addr());
    step(4'b0000, 4'b0000, rnd_addr());
    reset_pulse();
    rsp_seen = 0;
    step(4'hF, 4'hF, rnd_addr());
    idle(6);
    chk("post_rst_rsp", rsp_seen, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
